seven_seg_scan: RTL and testbench

- Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display.
- Takes a packed hex word, per-digit enable mask and decimal-point mask.
- Scans one digit per refresh period using an internal divider. Digit values are double-buffered so a frame never shows mixed old and new data.
- Sits between lab datapath logic and the board seg/an/dp pins; replaces the button-selected static display.

---
 rtl/seven_seg_pkg.sv | 39 +++
 rtl/seven_seg_scan_hex_to_seg.sv | 33 +++
 rtl/seven_seg_scan.sv | 201 ++++++++++++++++++++
 tb/tb_seven_seg_scan.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types, segment patterns and width helpers for the seven-segment scanner.
// Segment vectors are ordered g..a and are active-low (0 = segment lit).
package seven_seg_pkg;

   typedef logic [3:0] nibble_t;
   typedef logic [6:0] seg_t;

   // All cathodes off
   localparam seg_t SEG_BLANK = 7'b1111111;

   // Hex glyphs, g..a, active-low
   localparam seg_t SEG_HEX_0 = 7'b1000000;
   localparam seg_t SEG_HEX_1 = 7'b1111001;
   localparam seg_t SEG_HEX_2 = 7'b0100100;
   localparam seg_t SEG_HEX_3 = 7'b0110000;
   localparam seg_t SEG_HEX_4 = 7'b0011001;
   localparam seg_t SEG_HEX_5 = 7'b0010010;
   localparam seg_t SEG_HEX_6 = 7'b0000010;
   localparam seg_t SEG_HEX_7 = 7'b1111000;
   localparam seg_t SEG_HEX_8 = 7'b0000000;
   localparam seg_t SEG_HEX_9 = 7'b0010000;
   localparam seg_t SEG_HEX_A = 7'b0001000;
   localparam seg_t SEG_HEX_B = 7'b0000011;
   localparam seg_t SEG_HEX_C = 7'b1000110;
   localparam seg_t SEG_HEX_D = 7'b0100001;
   localparam seg_t SEG_HEX_E = 7'b0000110;
   localparam seg_t SEG_HEX_F = 7'b0001110;

   // Width of the refresh divider counter (counts 0..div-1)
   function automatic int cnt_width(input int div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

   // Width of the scan index; at least one bit even for a single digit
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seven_seg_scan_hex_to_seg.sv
// Combinational hex nibble to seven-segment (g..a, active-low) decoder.
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   // Map each hex value to its glyph
   always_comb begin
      seg_o = SEG_BLANK;
      case (nibble_i)
         4'h0:    seg_o = SEG_HEX_0;
         4'h1:    seg_o = SEG_HEX_1;
         4'h2:    seg_o = SEG_HEX_2;
         4'h3:    seg_o = SEG_HEX_3;
         4'h4:    seg_o = SEG_HEX_4;
         4'h5:    seg_o = SEG_HEX_5;
         4'h6:    seg_o = SEG_HEX_6;
         4'h7:    seg_o = SEG_HEX_7;
         4'h8:    seg_o = SEG_HEX_8;
         4'h9:    seg_o = SEG_HEX_9;
         4'hA:    seg_o = SEG_HEX_A;
         4'hB:    seg_o = SEG_HEX_B;
         4'hC:    seg_o = SEG_HEX_C;
         4'hD:    seg_o = SEG_HEX_D;
         4'hE:    seg_o = SEG_HEX_E;
         4'hF:    seg_o = SEG_HEX_F;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver.
// One digit is lit per refresh period; digit data is double-buffered
// (pending -> shadow at the end of each frame) so a frame never mixes
// old and new values. All pin outputs are registered.
// Optional build macro SEVEN_SEG_LZ_BLANK_EN enables leading-zero
// suppression (digit 0 is never suppressed; a lit dp keeps its digit).
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   output logic [6:0]              segment,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic                    frame_start
);

   localparam int CNT_W     = cnt_width(REFRESH_DIV);
   localparam int IDX_W     = idx_width(NUM_DIGITS);
   localparam int NUM_SLOTS = 1 << IDX_W;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   // Divider and scan position
   logic [CNT_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic             tick;
   logic             boundary;

   // Pending buffer (written by load) and shadow buffer (what is displayed)
   logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
   logic [NUM_DIGITS-1:0]   pend_en_q,  pend_en_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q,  pend_dp_d;
   logic [4*NUM_DIGITS-1:0] shad_dig_q, shad_dig_d;
   logic [NUM_DIGITS-1:0]   shad_en_q,  shad_en_d;
   logic [NUM_DIGITS-1:0]   shad_dp_q,  shad_dp_d;

   // Per-slot views of the next shadow contents, padded to a power of two
   // so the scan index can address them without range issues.
   logic [3:0] slot_nib [NUM_SLOTS];
   logic       slot_en  [NUM_SLOTS];
   logic       slot_dp  [NUM_SLOTS];
   logic       slot_sup [NUM_SLOTS];

   // Selected digit for the next output cycle
   logic [3:0]            sel_nib;
   logic [6:0]            sel_seg;
   logic                  sel_dp;
   logic                  show_d;
   logic [NUM_DIGITS-1:0] anode_d;

   // Registered pin drivers
   logic [NUM_DIGITS-1:0] anode_q;
   logic [6:0]            seg_q;
   logic                  dp_q;
   logic                  frame_start_q;

   // Next divider count and scan index; boundary marks the last cycle of a frame
   always_comb begin
      tick     = (count_q == CNT_LAST);
      boundary = tick && (index_q == IDX_LAST);
      count_d  = tick ? '0 : count_q + 1'b1;
      index_d  = index_q;
      if (tick) begin
         index_d = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
      end
   end

   // Next buffer contents: load fills pending; boundary promotes to shadow,
   // taking the live inputs directly when load coincides with the boundary
   always_comb begin
      pend_dig_d = pend_dig_q;
      pend_en_d  = pend_en_q;
      pend_dp_d  = pend_dp_q;
      shad_dig_d = shad_dig_q;
      shad_en_d  = shad_en_q;
      shad_dp_d  = shad_dp_q;
      if (load) begin
         pend_dig_d = digits;
         pend_en_d  = digit_en;
         pend_dp_d  = dp_in;
      end
      if (boundary) begin
         shad_dig_d = pend_dig_d;
         shad_en_d  = pend_en_d;
         shad_dp_d  = pend_dp_d;
      end
   end

   // Divider, scan index and both buffers
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= '0;
         index_q    <= '0;
         pend_dig_q <= '0;
         pend_en_q  <= '0;
         pend_dp_q  <= '0;
         shad_dig_q <= '0;
         shad_en_q  <= '0;
         shad_dp_q  <= '0;
      end else begin
         count_q    <= count_d;
         index_q    <= index_d;
         pend_dig_q <= pend_dig_d;
         pend_en_q  <= pend_en_d;
         pend_dp_q  <= pend_dp_d;
         shad_dig_q <= shad_dig_d;
         shad_en_q  <= shad_en_d;
         shad_dp_q  <= shad_dp_d;
      end
   end

   // Split the next shadow word into per-slot fields; unused slots read blank
   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
         if (gi < NUM_DIGITS) begin : g_real
            assign slot_nib[gi] = shad_dig_d[4*gi +: 4];
            assign slot_en[gi]  = shad_en_d[gi];
            assign slot_dp[gi]  = shad_dp_d[gi];
         end else begin : g_pad
            assign slot_nib[gi] = 4'h0;
            assign slot_en[gi]  = 1'b0;
            assign slot_dp[gi]  = 1'b0;
         end
      end
   endgenerate

`ifdef SEVEN_SEG_LZ_BLANK_EN
   // lz_run[i] is high when digit i and every digit above it is a zero
   // without a decimal point, i.e. still inside the leading-zero run.
   logic [NUM_DIGITS:1] lz_run;
   assign lz_run[NUM_DIGITS] = 1'b1;
   generate
      for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
         assign lz_run[gi] = lz_run[gi+1] && (slot_nib[gi] == 4'h0) && !slot_dp[gi];
      end
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_sup
         if (gi > 0 && gi < NUM_DIGITS) begin : g_on
            assign slot_sup[gi] = lz_run[gi];
         end else begin : g_off
            assign slot_sup[gi] = 1'b0;
         end
      end
   endgenerate
`else
   // Every enabled digit is shown, zeros included
   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_sup
         assign slot_sup[gi] = 1'b0;
      end
   endgenerate
`endif

   // Pick the digit that will be lit next cycle
   always_comb begin
      sel_nib = slot_nib[index_d];
      sel_dp  = slot_dp[index_d];
      show_d  = slot_en[index_d] && !slot_sup[index_d];
   end

   hex_to_seg u_hex_to_seg (
      .nibble_i (sel_nib),
      .seg_o    (sel_seg)
   );

   // One active-low anode for the selected digit, only when it is shown
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
         assign anode_d[gi] = !(show_d && (index_d == IDX_W'(gi)));
      end
   endgenerate

   // Pin registers; reset turns every anode and cathode off
   always_ff @(posedge clk) begin
      if (reset) begin
         anode_q       <= '1;
         seg_q         <= SEG_BLANK;
         dp_q          <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         anode_q       <= anode_d;
         seg_q         <= show_d ? sel_seg : SEG_BLANK;
         dp_q          <= show_d ? ~sel_dp : 1'b1;
         frame_start_q <= boundary;
      end
   end

   assign anode       = anode_q;
   assign segment     = seg_q;
   assign dp          = dp_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (NUM_DIGITS=4, REFRESH_DIV=4).
// A cycle-count based model predicts every pin on every cycle; directed
// literal checks pin the model to hand-computed values.
module tb_seven_seg_scan;

   localparam int N     = 4;
   localparam int DIV   = 4;
   localparam int FRAME = N * DIV;

   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] HEX_TAB [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   digits;
   logic [3:0]    digit_en;
   logic [3:0]    dp_in;
   logic          load;
   logic [6:0]    segment;
   logic          dp;
   logic [3:0]    anode;
   logic          frame_start;

   seven_seg_scan #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
      .clk         (clk),
      .reset       (reset),
      .digits      (digits),
      .digit_en    (digit_en),
      .dp_in       (dp_in),
      .load        (load),
      .segment     (segment),
      .dp          (dp),
      .anode       (anode),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // Model: m_cycle counts cycles since reset release; a frame is FRAME
   // cycles, the visible slot is (cycle / DIV) % N, and the shadow copy
   // happens on the last cycle of each frame.
   int          m_cycle = 0;
   logic [15:0] m_pdig = '0, m_sdig = '0;
   logic [3:0]  m_pen = '0, m_sen = '0, m_pdp = '0, m_sdp = '0;
   logic [3:0]  exp_anode = '1;
   logic [6:0]  exp_seg = 7'b1111111;
   logic        exp_dp = 1'b1, exp_fs = 1'b0;
   int          m_slot;
   logic [3:0]  m_nib;
   logic        m_show, m_lead;

   always @(posedge clk) begin
      if (reset) begin
         m_cycle = 0;
         m_pdig = '0; m_pen = '0; m_pdp = '0;
         m_sdig = '0; m_sen = '0; m_sdp = '0;
         exp_anode = 4'b1111; exp_seg = BLANK; exp_dp = 1'b1; exp_fs = 1'b0;
      end else begin
         if (load) begin
            m_pdig = digits; m_pen = digit_en; m_pdp = dp_in;
         end
         if (m_cycle % FRAME == FRAME - 1) begin
            m_sdig = m_pdig; m_sen = m_pen; m_sdp = m_pdp;
         end
         m_cycle++;
         m_slot = (m_cycle / DIV) % N;
         m_nib  = m_sdig[4*m_slot +: 4];
         m_show = m_sen[m_slot];
`ifdef SEVEN_SEG_LZ_BLANK_EN
         if (m_slot > 0) begin
            m_lead = 1'b1;
            for (int j = m_slot; j < N; j++)
               if (m_sdig[4*j +: 4] != 4'h0 || m_sdp[j]) m_lead = 1'b0;
            if (m_lead) m_show = 1'b0;
         end
`endif
         exp_anode = 4'b1111;
         if (m_show) exp_anode[m_slot] = 1'b0;
         exp_seg = m_show ? HEX_TAB[m_nib] : BLANK;
         exp_dp  = m_show ? ~m_sdp[m_slot] : 1'b1;
         exp_fs  = (m_cycle % FRAME == 0);
      end
   end

   int tests = 0;
   int fails = 0;

   task automatic check_cycle();
      tests++;
      if (anode !== exp_anode || segment !== exp_seg || dp !== exp_dp || frame_start !== exp_fs) begin
         fails++;
         $display("FAIL cycle_cmp t=%0t got anode=%b seg=%b dp=%b fs=%b, expected anode=%b seg=%b dp=%b fs=%b",
                  $time, anode, segment, dp, frame_start, exp_anode, exp_seg, exp_dp, exp_fs);
      end
   endtask

   task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] expv);
      tests++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, expv);
      end
   endtask

   // Advance to the next falling edge and compare all pins with the model
   task automatic step();
      @(negedge clk);
      check_cycle();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Step until frame_start is seen (bounded); returns cycles taken
   task automatic wait_fs(output int cnt);
      cnt = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         step();
         cnt++;
         if (frame_start === 1'b1) break;
      end
      check_lit("frame_start_seen", {31'b0, frame_start}, 32'd1);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p);
      digits = d; digit_en = e; dp_in = p; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   int cnt;

   initial begin
      reset = 1'b1; digits = '0; digit_en = '0; dp_in = '0; load = 1'b0;

      // Reset held 3 cycles: pins blank
      for (int i = 0; i < 3; i++) begin
         step();
         check_lit("reset_anode", {28'b0, anode}, 32'hF);
         check_lit("reset_seg", {25'b0, segment}, 32'h7F);
         check_lit("reset_dp", {31'b0, dp}, 32'd1);
      end
      reset = 1'b0;
      wait_fs(cnt);
      check_lit("first_fs_cycle", cnt, 32'd16);
      check_lit("first_frame_blank", {28'b0, anode}, 32'hF);

      // 1234 on all digits
      do_load(16'h1234, 4'hF, 4'h0);
      wait_fs(cnt);
      check_lit("1234_slot0_anode", {28'b0, anode}, 32'b1110);
      check_lit("1234_slot0_seg", {25'b0, segment}, 32'b0011001);
      steps(4);
      check_lit("1234_slot1_anode", {28'b0, anode}, 32'b1101);
      check_lit("1234_slot1_seg", {25'b0, segment}, 32'b0110000);

      // Two loads within one frame: only the last one is shown
      wait_fs(cnt);
      steps(5);
      do_load(16'hABCD, 4'hF, 4'h0);
      steps(3);
      do_load(16'h00EF, 4'hF, 4'h0);
      wait_fs(cnt);
      check_lit("lastwins_slot0_seg", {25'b0, segment}, 32'b0001110);
      steps(4);
      check_lit("lastwins_slot1_seg", {25'b0, segment}, 32'b0000110);

      // Load exactly on the boundary cycle
      wait_fs(cnt);
      steps(FRAME - 1);
      do_load(16'h5555, 4'hF, 4'h0);
      check_lit("bnd_fs", {31'b0, frame_start}, 32'd1);
      check_lit("bnd_seg", {25'b0, segment}, 32'b0010010);
      check_lit("bnd_anode", {28'b0, anode}, 32'b1110);

      // Sparse enables with a decimal point on digit 0
      do_load(16'h1234, 4'b0101, 4'b0001);
      wait_fs(cnt);
      check_lit("en_slot0_anode", {28'b0, anode}, 32'b1110);
      check_lit("en_slot0_dp", {31'b0, dp}, 32'd0);
      steps(4);
      check_lit("en_slot1_anode", {28'b0, anode}, 32'b1111);
      check_lit("en_slot1_seg", {25'b0, segment}, 32'h7F);
      check_lit("en_slot1_dp", {31'b0, dp}, 32'd1);
      steps(4);
      check_lit("en_slot2_anode", {28'b0, anode}, 32'b1011);
      check_lit("en_slot2_dp", {31'b0, dp}, 32'd1);
      check_lit("en_slot2_seg", {25'b0, segment}, 32'b0100100);

      // 0070: digit 0 and digit 1 always visible; then reset mid-frame
      do_load(16'h0070, 4'hF, 4'h0);
      wait_fs(cnt);
      check_lit("lz_slot0_seg", {25'b0, segment}, 32'b1000000);
      steps(4);
      check_lit("lz_slot1_seg", {25'b0, segment}, 32'b1111000);
      steps(2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_lit("midreset_anode", {28'b0, anode}, 32'hF);
      check_lit("midreset_seg", {25'b0, segment}, 32'h7F);
      wait_fs(cnt);
      check_lit("midreset_fs_cycle", cnt, 32'd16);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         digits   = 16'($urandom);
         if ($urandom_range(0, 1) == 0) digits[15:8] = 8'h00;
         if ($urandom_range(0, 3) == 0) digits[7:4] = 4'h0;
         digit_en = 4'($urandom);
         dp_in    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         load     = ($urandom_range(0, 7) == 0);
         reset    = ($urandom_range(0, 599) == 0);
         step();
      end
      reset = 1'b0; load = 1'b0;
      steps(2 * FRAME);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
